// File: rtl/hid_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hid_ctrl
// Brief  : Framed HID command decoder driving a keyboard matrix, a quadrature
//          mouse, NUM_JOY joystick registers and a readback byte.
// Rev    : 1.0 - initial release
// ============================================================================
module hid_ctrl #(
    parameter int         NUM_JOY  = 2,
    parameter int         KBD_ROWS = 8,
    parameter int         KBD_COLS = 8,
    parameter int         MDIV_W   = 14,
    parameter logic [7:0] VERSION  = 8'h43
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_in_strobe,
    input  logic                  data_in_start,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    output logic [1:0]            mouse_btns,
    output logic [1:0]            mouse_x,
    output logic [1:0]            mouse_y,
    output logic [8*NUM_JOY-1:0]  joystick,
    input  logic [KBD_ROWS-1:0]   kbd_row_sel,
    output logic [KBD_COLS-1:0]   kbd_col,
    output logic                  key_event
);

    localparam logic [7:0] c_CMD_STATUS = 8'd0;
    localparam logic [7:0] c_CMD_KEY    = 8'd1;
    localparam logic [7:0] c_CMD_MOUSE  = 8'd2;
    localparam logic [7:0] c_CMD_JOY_WR = 8'd3;
    localparam logic [7:0] c_CMD_KCLR   = 8'd4;
    localparam logic [7:0] c_CMD_JOY_RD = 8'd5;

    logic [7:0]                   r_cmd;
    logic [3:0]                   r_idx;      // 0 means no frame open
    logic [7:0]                   r_dev;
    logic [7:0]                   r_data_out;
    logic [1:0]                   r_btns;
    logic [8*NUM_JOY-1:0]         r_joy;
    logic [KBD_ROWS*KBD_COLS-1:0] r_keys;
    logic [KBD_ROWS*KBD_COLS-1:0] w_keys_next;
    logic                         r_key_event;
    logic [MDIV_W-1:0]            r_div;
    logic [7:0]                   r_acc_x, r_acc_y;
    logic [1:0]                   r_qx, r_qy;
    logic                         r_pend_x, r_pend_y;
    logic                         w_payload, w_wr_x, w_wr_y, w_tick;
    logic [7:0]                   w_joy_rd;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {a[7], a} + {b[7], b};
        if (s[8] != s[7]) return s[8] ? 8'h80 : 8'h7F;
        return s[7:0];
    endfunction

    function automatic logic [1:0] q_fwd(input logic [1:0] q);
        return {q[0], ~q[1]};
    endfunction

    function automatic logic [1:0] q_rev(input logic [1:0] q);
        return {~q[0], q[1]};
    endfunction

    assign w_payload = data_in_strobe && !data_in_start && (r_idx != 4'd0);
    assign w_wr_x    = w_payload && (r_cmd == c_CMD_MOUSE) && (r_idx == 4'd2);
    assign w_wr_y    = w_payload && (r_cmd == c_CMD_MOUSE) && (r_idx == 4'd3);
    assign w_tick    = &r_div;

    always_comb begin
        w_joy_rd = 8'h00;
        for (int j = 0; j < NUM_JOY; j++)
            if (data_in == 8'(j)) w_joy_rd = r_joy[8*j +: 8];
    end

    // Out-of-range row/col codes simply match no matrix position.
    always_comb begin
        w_keys_next = r_keys;
        if (data_in_strobe && data_in_start && (data_in == c_CMD_KCLR)) begin
            w_keys_next = '1;
        end else if (w_payload && (r_cmd == c_CMD_KEY) && (r_idx == 4'd1)) begin
            for (int r = 0; r < KBD_ROWS; r++)
                for (int c = 0; c < KBD_COLS; c++)
                    if (data_in[2:0] == 3'(r) && data_in[5:3] == 3'(c))
                        w_keys_next[r*KBD_COLS + c] = data_in[7];
        end
    end

    always_comb begin
        kbd_col = '1;
        for (int r = 0; r < KBD_ROWS; r++)
            if (!kbd_row_sel[r]) kbd_col = kbd_col & r_keys[r*KBD_COLS +: KBD_COLS];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_keys      <= '1;
            r_key_event <= 1'b0;
        end else begin
            r_keys      <= w_keys_next;
            r_key_event <= (w_keys_next != r_keys);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd      <= 8'h00;
            r_idx      <= 4'd0;
            r_dev      <= 8'h00;
            r_data_out <= 8'h00;
            r_btns     <= 2'b00;
            r_joy      <= '0;
        end else if (data_in_strobe) begin
            if (data_in_start) begin
                r_cmd <= data_in;
                r_idx <= 4'd1;
            end else if (r_idx != 4'd0) begin
                if (r_idx != 4'd15) r_idx <= r_idx + 4'd1;
                case (r_cmd)
                    c_CMD_STATUS: begin
                        if (r_idx == 4'd1)      r_data_out <= 8'h5C;
                        else if (r_idx == 4'd2) r_data_out <= VERSION;
                        else if (r_idx == 4'd3) r_data_out <= 8'(NUM_JOY);
                    end
                    c_CMD_MOUSE: if (r_idx == 4'd1) r_btns <= data_in[1:0];
                    c_CMD_JOY_WR: begin
                        if (r_idx == 4'd1) r_dev <= data_in;
                        else if (r_idx == 4'd2)
                            for (int j = 0; j < NUM_JOY; j++)
                                if (r_dev == 8'(j)) r_joy[8*j +: 8] <= data_in;
                    end
                    c_CMD_JOY_RD: if (r_idx == 4'd1) r_data_out <= w_joy_rd;
                    default: ;
                endcase
            end
        end
    end

    // A tick colliding with an accumulator write is held over one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div    <= '0;
            r_acc_x  <= 8'h00;
            r_acc_y  <= 8'h00;
            r_qx     <= 2'b00;
            r_qy     <= 2'b00;
            r_pend_x <= 1'b0;
            r_pend_y <= 1'b0;
        end else begin
            r_div <= r_div + MDIV_W'(1);
            if (w_wr_x) begin
                r_acc_x  <= sat_add(r_acc_x, data_in);
                r_pend_x <= r_pend_x | w_tick;
            end else if (w_tick || r_pend_x) begin
                r_pend_x <= 1'b0;
                if (r_acc_x[7]) begin
                    r_acc_x <= r_acc_x + 8'd1;
                    r_qx    <= q_rev(r_qx);
                end else if (r_acc_x != 8'd0) begin
                    r_acc_x <= r_acc_x - 8'd1;
                    r_qx    <= q_fwd(r_qx);
                end
            end
            if (w_wr_y) begin
                r_acc_y  <= sat_add(r_acc_y, data_in);
                r_pend_y <= r_pend_y | w_tick;
            end else if (w_tick || r_pend_y) begin
                r_pend_y <= 1'b0;
                if (r_acc_y[7]) begin
                    r_acc_y <= r_acc_y + 8'd1;
                    r_qy    <= q_rev(r_qy);
                end else if (r_acc_y != 8'd0) begin
                    r_acc_y <= r_acc_y - 8'd1;
                    r_qy    <= q_fwd(r_qy);
                end
            end
        end
    end

    assign data_out   = r_data_out;
    assign mouse_btns = r_btns;
    assign mouse_x    = r_qx;
    assign mouse_y    = r_qy;
    assign joystick   = r_joy;
    assign key_event  = r_key_event;

endmodule
`default_nettype wire
